// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared state, error-code and rotate definitions for the ring counter family
package ring_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        ERR     = 2'd3
    } ring_state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISMATCH = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    // Widest ring the rotate helper supports; callers zero-extend into it.
    localparam int ROT_MAX_W = 32;

    // One-step rotate of the low 'width' bits: dir=0 right, dir=1 left.
    function automatic logic [ROT_MAX_W-1:0] rot(input logic [ROT_MAX_W-1:0] value,
                                                 input int                   width,
                                                 input bit                   dir);
        logic [ROT_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < ROT_MAX_W; i++) begin
            if (i < width) begin
                if (!dir) begin
                    r[i] = (i == width - 1) ? value[0] : value[(i + 1) % ROT_MAX_W];
                end else begin
                    r[i] = (i == 0) ? value[width - 1] : value[(i + ROT_MAX_W - 1) % ROT_MAX_W];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ring_rotator.sv
// rtl/ring_rotator.sv - combinational one-step ring rotate in direction DIR
module ring_rotator
    import ring_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter bit DIR   = 1'b0
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // Widen into the shared helper and keep only the ring bits of the result.
    assign dout = WIDTH'(rot(ROT_MAX_W'(din), WIDTH, DIR));

endmodule

// File: rtl/ring_phase_monitor.sv
// rtl/ring_phase_monitor.sv - ring state checker/phase decoder; option macro RING_PHASE_MONITOR_AUTORESYNC_EN
module ring_phase_monitor
    import ring_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter bit DIR    = 1'b0,
    parameter int REV_W  = 8,
    parameter int ACQ_TO = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic                     en,
    input  logic [WIDTH-1:0]         seed,
    input  logic [WIDTH-1:0]         ring_in,
    output logic                     locked,
    output logic                     phase_vld,
    output logic [$clog2(WIDTH)-1:0] phase_idx,
    output logic [REV_W-1:0]         rev_cnt,
    output logic                     err,
    output logic [1:0]               err_code
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int ACQ_W = $clog2(ACQ_TO + 1);

    ring_state_e      state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] exp_rot;
    logic [ACQ_W-1:0] acq_cnt_q, acq_cnt_d;
    logic             locked_q, locked_d;
    logic             phase_vld_q, phase_vld_d;
    logic [IDX_W-1:0] phase_idx_q, phase_idx_d;
    logic [REV_W-1:0] rev_cnt_q, rev_cnt_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
`ifdef RING_PHASE_MONITOR_AUTORESYNC_EN
    logic [WIDTH-1:0] seed_q, seed_d;
`endif

    ring_rotator #(
        .WIDTH (WIDTH),
        .DIR   (DIR)
    ) u_rot (
        .din  (exp_q),
        .dout (exp_rot)
    );

    // Next-state: start wins over any same-cycle sample; en gates all progress.
    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        acq_cnt_d   = acq_cnt_q;
        locked_d    = locked_q;
        phase_vld_d = 1'b0;
        phase_idx_d = phase_idx_q;
        rev_cnt_d   = rev_cnt_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
`ifdef RING_PHASE_MONITOR_AUTORESYNC_EN
        seed_d      = seed_q;
        // A resync mismatch only flags err for the cycle after it happened.
        if (state_q == ACQUIRE) begin
            err_d = 1'b0;
        end
`endif
        if (start) begin
            state_d     = ACQUIRE;
            exp_d       = seed;
            acq_cnt_d   = '0;
            locked_d    = 1'b0;
            phase_idx_d = '0;
            rev_cnt_d   = '0;
            err_d       = 1'b0;
            err_code_d  = ERR_NONE;
`ifdef RING_PHASE_MONITOR_AUTORESYNC_EN
            seed_d      = seed;
`endif
        end else if (en) begin
            case (state_q)
                ACQUIRE: begin
                    if (ring_in == exp_q) begin
                        state_d     = TRACK;
                        exp_d       = exp_rot;
                        phase_idx_d = '0;
                        locked_d    = 1'b1;
                    end else begin
                        acq_cnt_d = acq_cnt_q + 1'b1;
                        if (acq_cnt_q == ACQ_W'(ACQ_TO - 1)) begin
                            state_d    = ERR;
                            err_d      = 1'b1;
                            err_code_d = ERR_TIMEOUT;
                        end
                    end
                end
                TRACK: begin
                    if (ring_in == exp_q) begin
                        phase_vld_d = 1'b1;
                        exp_d       = exp_rot;
                        if (phase_idx_q == IDX_W'(WIDTH - 1)) begin
                            phase_idx_d = '0;
                            if (rev_cnt_q != '1) begin
                                rev_cnt_d = rev_cnt_q + 1'b1;
                            end
                        end else begin
                            phase_idx_d = phase_idx_q + 1'b1;
                        end
                    end else begin
                        locked_d   = 1'b0;
                        err_d      = 1'b1;
                        err_code_d = ERR_MISMATCH;
`ifdef RING_PHASE_MONITOR_AUTORESYNC_EN
                        state_d    = ACQUIRE;
                        exp_d      = seed_q;
                        acq_cnt_d  = '0;
`else
                        state_d    = ERR;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            exp_q       <= '0;
            acq_cnt_q   <= '0;
            locked_q    <= 1'b0;
            phase_vld_q <= 1'b0;
            phase_idx_q <= '0;
            rev_cnt_q   <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
`ifdef RING_PHASE_MONITOR_AUTORESYNC_EN
            seed_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            acq_cnt_q   <= acq_cnt_d;
            locked_q    <= locked_d;
            phase_vld_q <= phase_vld_d;
            phase_idx_q <= phase_idx_d;
            rev_cnt_q   <= rev_cnt_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
`ifdef RING_PHASE_MONITOR_AUTORESYNC_EN
            seed_q      <= seed_d;
`endif
        end
    end

    assign locked    = locked_q;
    assign phase_vld = phase_vld_q;
    assign phase_idx = phase_idx_q;
    assign rev_cnt   = rev_cnt_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// tb/tb_ring_phase_monitor.sv - scoreboard bench for ring_phase_monitor (WIDTH=4, DIR=0, REV_W=2, ACQ_TO=16)
module tb_ring_phase_monitor;

    logic       clk;
    logic       rstn;
    logic       start;
    logic       en;
    logic [3:0] seed;
    logic [3:0] ring_in;
    logic       locked;
    logic       phase_vld;
    logic [1:0] phase_idx;
    logic [1:0] rev_cnt;
    logic       err;
    logic [1:0] err_code;

    ring_phase_monitor #(
        .WIDTH  (4),
        .DIR    (1'b0),
        .REV_W  (2),
        .ACQ_TO (16)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .en        (en),
        .seed      (seed),
        .ring_in   (ring_in),
        .locked    (locked),
        .phase_vld (phase_vld),
        .phase_idx (phase_idx),
        .rev_cnt   (rev_cnt),
        .err       (err),
        .err_code  (err_code)
    );

    typedef struct {
        logic       vld;
        logic [1:0] idx;
        logic [1:0] rev;
        logic       lck;
        logic       er;
        logic [1:0] code;
        int         tag;
    } rec_t;

    rec_t       sb_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         step_no  = 0;
    logic [3:0] trk [0:3];

    localparam logic [3:0] B = 4'b1011;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_rec(input rec_t r);
        n_checks++;
        if (phase_vld === r.vld && phase_idx === r.idx && rev_cnt === r.rev &&
            locked === r.lck && err === r.er && err_code === r.code) begin
            n_pass++;
        end else begin
            $display("FAIL step%0d: got vld=%b idx=%0d rev=%0d locked=%b err=%b code=%b, want vld=%b idx=%0d rev=%0d locked=%b err=%b code=%b",
                     r.tag, phase_vld, phase_idx, rev_cnt, locked, err, err_code,
                     r.vld, r.idx, r.rev, r.lck, r.er, r.code);
        end
    endtask

    // Monitor: each negedge compares outputs of the preceding edge against the oldest expectation.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            check_rec(sb_q.pop_front());
        end
    end

    // Drive one cycle of inputs, then queue what the outputs must show after that edge.
    task automatic step(input logic st, input logic e, input logic [3:0] sd, input logic [3:0] ri,
                        input logic vld, input logic [1:0] idx, input logic [1:0] rev,
                        input logic lck, input logic er, input logic [1:0] code);
        rec_t r;
        start   = st;
        en      = e;
        seed    = sd;
        ring_in = ri;
        @(posedge clk);
        #1;
        r.vld = vld; r.idx = idx; r.rev = rev; r.lck = lck; r.er = er; r.code = code;
        r.tag = step_no;
        step_no++;
        sb_q.push_back(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t rr;
        int   revs;
        trk[0] = 4'b1101; trk[1] = 4'b1110; trk[2] = 4'b0111; trk[3] = 4'b1011;
        rstn = 1'b0; start = 1'b0; en = 1'b0; seed = '0; ring_in = '0;

        // Reset values
        step(0, 1, B, B, 0, 0, 0, 0, 0, 2'b00);
        step(1, 1, B, B, 0, 0, 0, 0, 0, 2'b00);
        rstn = 1'b1;

        // Lock and track one revolution
        step(1, 0, B, 4'b0000, 0, 0, 0, 0, 0, 2'b00);
        step(0, 1, B, 4'b1011, 0, 0, 0, 1, 0, 2'b00);
        step(0, 1, B, 4'b1101, 1, 1, 0, 1, 0, 2'b00);
        step(0, 1, B, 4'b1110, 1, 2, 0, 1, 0, 2'b00);
        step(0, 1, B, 4'b0111, 1, 3, 0, 1, 0, 2'b00);
        step(0, 1, B, 4'b1011, 1, 0, 1, 1, 0, 2'b00);

        // en toggling: progress only on enabled cycles
        step(0, 0, B, 4'b0000, 0, 0, 1, 1, 0, 2'b00);
        step(0, 1, B, 4'b1101, 1, 1, 1, 1, 0, 2'b00);
        step(0, 0, B, 4'b1101, 0, 1, 1, 1, 0, 2'b00);
        step(0, 1, B, 4'b1110, 1, 2, 1, 1, 0, 2'b00);

        // Mismatch in TRACK (0111 expected)
        step(0, 1, B, 4'b1111, 0, 2, 1, 0, 1, 2'b01);
`ifdef RING_PHASE_MONITOR_AUTORESYNC_EN
        step(0, 1, B, 4'b0111, 0, 2, 1, 0, 0, 2'b01);
        step(0, 1, B, 4'b1011, 0, 0, 1, 1, 0, 2'b01);
        step(0, 1, B, 4'b1101, 1, 1, 1, 1, 0, 2'b01);
`else
        step(0, 1, B, 4'b0111, 0, 2, 1, 0, 1, 2'b01);
        step(0, 1, B, 4'b1011, 0, 2, 1, 0, 1, 2'b01);
        step(0, 0, B, 4'b1011, 0, 2, 1, 0, 1, 2'b01);
`endif
        step(1, 0, B, 4'b0000, 0, 0, 0, 0, 0, 2'b00);

        // Acquire timeout on the 16th unmatched sample, then sticky
        for (int k = 0; k < 15; k++) begin
            step(0, 1, B, 4'b0000, 0, 0, 0, 0, 0, 2'b00);
        end
        step(0, 1, B, 4'b0000, 0, 0, 0, 0, 1, 2'b10);
        step(0, 1, B, 4'b1011, 0, 0, 0, 0, 1, 2'b10);

        // Five revolutions: rev_cnt saturates at 3
        step(1, 0, B, 4'b0000, 0, 0, 0, 0, 0, 2'b00);
        step(0, 1, B, 4'b1011, 0, 0, 0, 1, 0, 2'b00);
        for (int k = 0; k < 20; k++) begin
            revs = (k + 1) / 4;
            if (revs > 3) revs = 3;
            step(0, 1, B, trk[k % 4], 1, 2'((k + 1) % 4), 2'(revs), 1, 0, 2'b00);
        end
        step(0, 1, B, 4'b1101, 1, 1, 3, 1, 0, 2'b00);

        // Asynchronous reset between edges mid-TRACK
        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        rr.vld = 0; rr.idx = 0; rr.rev = 0; rr.lck = 0; rr.er = 0; rr.code = 2'b00; rr.tag = -1;
        check_rec(rr);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // IDLE ignores samples
        step(0, 1, B, 4'b1011, 0, 0, 0, 0, 0, 2'b00);

        // Periodic seed 1010
        step(1, 0, 4'b1010, 4'b0000, 0, 0, 0, 0, 0, 2'b00);
        step(0, 1, 4'b1010, 4'b1010, 0, 0, 0, 1, 0, 2'b00);
        step(0, 1, 4'b1010, 4'b0101, 1, 1, 0, 1, 0, 2'b00);
        step(0, 1, 4'b1010, 4'b1010, 1, 2, 0, 1, 0, 2'b00);
        step(0, 1, 4'b1010, 4'b0101, 1, 3, 0, 1, 0, 2'b00);
        step(0, 1, 4'b1010, 4'b1010, 1, 0, 1, 1, 0, 2'b00);

        // start beats a same-cycle matching sample, then relock on new seed
        step(1, 1, B, 4'b0101, 0, 0, 0, 0, 0, 2'b00);
        step(0, 1, B, 4'b1011, 0, 0, 0, 1, 0, 2'b00);
        step(0, 1, B, 4'b1101, 1, 1, 0, 1, 0, 2'b00);

        start = 1'b0;
        en    = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
